// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the nlp-16a ALU control-bit decoders.
// Strobe polarity and the forced Ctrl values live here so sibling decoders agree.
package alu_ctrl_pkg;

  localparam logic STROBE_ACTIVE = 1'b0;
  localparam logic STROBE_IDLE   = 1'b1;

  localparam logic CTRL4_ADD = 1'b0;
  localparam logic CTRL4_SUB = 1'b1;

  typedef enum logic [2:0] {
    MODE_INT_DEC = 3'd0,
    MODE_INT_INC = 3'd1,
    MODE_INT_MOV = 3'd2,
    MODE_ADDRESS = 3'd3,
    MODE_NORMAL  = 3'd4
  } alu_mode_e;

  function automatic logic strobe_on(input logic strobe);
    return strobe == STROBE_ACTIVE;
  endfunction

endpackage

// File: rtl/decode_ctrl4_comb.sv
// Pure priority decode of ALU Ctrl4; no state, reusable by the Ctrl0-Ctrl3 decoders.
// Written as AND/OR terms rather than if/else so X on an input propagates instead of being masked.
module decode_ctrl4_comb
  import alu_ctrl_pkg::*;
(
  input  logic ctrl4,
  input  logic internal_mov,
  input  logic address_mode,
  input  logic internal_inc_dec,
  input  logic internal_dec,
  output logic ctrl4_next
);

  logic is_internal;
  logic is_inc_dec;
  logic is_dec;
  logic is_address;
  logic sub_term;
  logic pass_term;

  always_comb begin
    is_internal = strobe_on(internal_mov);
    is_inc_dec  = strobe_on(internal_inc_dec);
    is_dec      = strobe_on(internal_dec);
    is_address  = strobe_on(address_mode);

    // Only internal DEC forces SUB; INC, MOV and address mode all force ADD (0),
    // so the normal pass-through is the only other term that can produce a 1.
    sub_term  = is_internal & is_inc_dec & is_dec & CTRL4_SUB;
    pass_term = ~is_internal & ~is_address & ctrl4;

    ctrl4_next = sub_term | pass_term | CTRL4_ADD;
  end

endmodule

// File: rtl/decode_ctrl4.sv
// Registered ALU Ctrl4 decoder: priority decode followed by one output flop.
// The flop guarantees the ALU sees a stable Ctrl4 for a full cycle.
module decode_ctrl4
  import alu_ctrl_pkg::*;
#(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic Ctrl4,
  input  logic INTERNAL_MOV,
  input  logic ADDRESS_MODE,
  input  logic INTERNAL_INC_DEC,
  input  logic INTERNAL_DEC,
  output logic Ctrl4_out
);

  logic ctrl4_next;

  decode_ctrl4_comb u_comb (
    .ctrl4            (Ctrl4),
    .internal_mov     (INTERNAL_MOV),
    .address_mode     (ADDRESS_MODE),
    .internal_inc_dec (INTERNAL_INC_DEC),
    .internal_dec     (INTERNAL_DEC),
    .ctrl4_next       (ctrl4_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      Ctrl4_out <= RESET_VALUE;
    end else begin
      Ctrl4_out <= ctrl4_next;
    end
  end

endmodule

// File: tb/tb_decode_ctrl4.sv
// Directed self-checking bench for decode_ctrl4.
// Inputs change on the falling edge; the output is sampled 1 time unit after the rising edge.
module tb_decode_ctrl4;

  logic clk = 1'b0;
  logic rst;
  logic ctrl4;
  logic int_mov;
  logic addr_mode;
  logic int_inc_dec;
  logic int_dec;
  logic ctrl4_out;

  int checks = 0;
  int passed = 0;
  logic prev_exp;

  decode_ctrl4 #(.RESET_VALUE(1'b0)) dut (
    .clk              (clk),
    .rst              (rst),
    .Ctrl4            (ctrl4),
    .INTERNAL_MOV     (int_mov),
    .ADDRESS_MODE     (addr_mode),
    .INTERNAL_INC_DEC (int_inc_dec),
    .INTERNAL_DEC     (int_dec),
    .Ctrl4_out        (ctrl4_out)
  );

  always #5 clk = ~clk;

  function automatic logic model(input logic c4, input logic mov, input logic addr,
                                 input logic incdec, input logic dec);
    if (mov == 1'b0) begin
      if (incdec == 1'b0) return (dec == 1'b0) ? 1'b1 : 1'b0;
      return 1'b0;
    end
    if (addr == 1'b0) return 1'b0;
    return c4;
  endfunction

  task automatic applyStimulus(input logic r, input logic c4, input logic mov,
                               input logic addr, input logic incdec, input logic dec);
    @(negedge clk);
    rst         = r;
    ctrl4       = c4;
    int_mov     = mov;
    addr_mode   = addr;
    int_inc_dec = incdec;
    int_dec     = dec;
  endtask

  task automatic checkOutput(input logic expected, input string tag);
    checks = checks + 1;
    assert (ctrl4_out === expected) passed = passed + 1;
    else $error("[TB] FAIL %s: observed=%b expected=%b", tag, ctrl4_out, expected);
  endtask

  task automatic stepAndCheck(input logic r, input logic c4, input logic mov,
                              input logic addr, input logic incdec, input logic dec,
                              input logic expected, input string tag);
    applyStimulus(r, c4, mov, addr, incdec, dec);
    @(posedge clk);
    #1;
    checkOutput(expected, tag);
  endtask

  initial begin
    // Reset while the inputs would otherwise decode to 1
    stepAndCheck(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "reset_state");
    stepAndCheck(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "reset_hold");

    stepAndCheck(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "normal_c4_0");
    stepAndCheck(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "normal_c4_1");

    stepAndCheck(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "int_mov_c4_0");
    stepAndCheck(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "int_mov_c4_1");
    stepAndCheck(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "int_inc_c4_0");
    stepAndCheck(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "int_inc_c4_1");
    stepAndCheck(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "int_dec_c4_0");
    stepAndCheck(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "int_dec_c4_1");
    stepAndCheck(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "dec_to_inc");
    stepAndCheck(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "mov_ignores_dec");

    stepAndCheck(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "addr_mode_add");
    stepAndCheck(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "dec_over_addr");
    stepAndCheck(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "mov_over_addr");

    stepAndCheck(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ignored_strobes_c4_0");
    stepAndCheck(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "ignored_strobes_c4_1");

    // Reset mid-DEC discards the decode; release reloads it on the next edge
    stepAndCheck(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "dec_before_reset");
    stepAndCheck(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "reset_mid_dec");
    stepAndCheck(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "dec_after_reset");

    // Sweep all strobe combinations; before each edge the output must still hold the previous value
    prev_exp = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] s;
      logic       exp;
      s   = i[3:0];
      exp = model(1'b1, s[3], s[2], s[1], s[0]);
      applyStimulus(1'b0, 1'b1, s[3], s[2], s[1], s[0]);
      #1;
      checkOutput(prev_exp, $sformatf("sweep_hold_%0d", i));
      @(posedge clk);
      #1;
      checkOutput(exp, $sformatf("sweep_load_%0d", i));
      prev_exp = exp;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
